// File: rtl/paeth_pkg.sv
// paeth_pkg: shared constants and pixel/sample types for the Paeth predictor.
package paeth_pkg;
  localparam int LANE_W = 10;
  localparam int LANES = 3;
  localparam int BLK = 4;
  localparam int NBR = 8;
  typedef logic [LANE_W*LANES-1:0] pix_t;
  typedef logic [LANE_W-1:0] sample_t;
endpackage

// File: rtl/paeth_lane.sv
// paeth_lane: combinational Paeth selection for one unsigned 10-bit sample lane.
module paeth_lane
  import paeth_pkg::*;
(
  input  sample_t l,
  input  sample_t t,
  input  sample_t tl,
  output sample_t y
);
  logic signed [11:0] d_t, d_l, d_s;
  logic [10:0] p_left, p_top, p_tl;
  // d_s = T + L - 2*TL spans -2046..+2046, so 12 signed bits never wrap
  always_comb begin
    d_t = $signed({2'b00, t}) - $signed({2'b00, tl});
    d_l = $signed({2'b00, l}) - $signed({2'b00, tl});
    d_s = d_t + d_l;
    p_left = d_t[11] ? 11'(-d_t) : d_t[10:0];
    p_top = d_l[11] ? 11'(-d_l) : d_l[10:0];
    p_tl = d_s[11] ? 11'(-d_s) : d_s[10:0];
    y = (p_left <= p_top && p_left <= p_tl) ? l : (p_top <= p_tl) ? t : tl;
  end
endmodule

// File: rtl/paeth_mode.sv
// paeth_mode: registered 4x4 AV1 Paeth intra predictor, three lanes per pixel word.
module paeth_mode
  import paeth_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  pix_t referencePixel,
  input  pix_t aboveRow [0:NBR-1],
  input  pix_t leftCol [0:NBR-1],
  output pix_t pred [0:BLK-1][0:BLK-1]
);
  logic [LANES-1:0][LANE_W-1:0] nxt [0:BLK-1][0:BLK-1];
  logic unused_nbr;
  assign unused_nbr = ^{aboveRow[4], aboveRow[5], aboveRow[6], aboveRow[7],
                        leftCol[4], leftCol[5], leftCol[6], leftCol[7]};
  for (genvar i = 0; i < BLK; i++) begin : g_row
    for (genvar j = 0; j < BLK; j++) begin : g_col
      for (genvar k = 0; k < LANES; k++) begin : g_lane
        paeth_lane u_lane (
          .l (leftCol[i][k*LANE_W +: LANE_W]),
          .t (aboveRow[j][k*LANE_W +: LANE_W]),
          .tl(referencePixel[k*LANE_W +: LANE_W]),
          .y (nxt[i][j][k])
        );
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BLK; i++)
        for (int j = 0; j < BLK; j++)
          pred[i][j] <= '0;
    end else begin
      for (int i = 0; i < BLK; i++)
        for (int j = 0; j < BLK; j++)
          pred[i][j] <= pix_t'(nxt[i][j]);
    end
  end
endmodule

// File: tb/tb_paeth_mode.sv
// tb_paeth_mode: directed self-checking bench for the 4x4 Paeth predictor.
module tb_paeth_mode;
  import paeth_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  pix_t ref_px;
  pix_t above [0:7];
  pix_t left_c [0:7];
  pix_t pred [0:3][0:3];
  int total = 0;
  int bad = 0;
  int a2 [4] = '{140, 235, 101, 56};
  int l2 [4] = '{5, 170, 12, 230};
  int e2 [4][4] = '{'{5, 150, 5, 5}, '{170, 235, 101, 56},
                    '{12, 150, 12, 12}, '{230, 235, 150, 150}};

  paeth_mode dut (
    .clk(clk), .rst_n(rst_n), .referencePixel(ref_px),
    .aboveRow(above), .leftCol(left_c), .pred(pred)
  );

  always #5 clk = ~clk;

  function automatic int ref_lane(int l, int t, int tl);
    int pl, pt, s, ps;
    pl = (t > tl) ? t - tl : tl - t;
    pt = (l > tl) ? l - tl : tl - l;
    s = t + l - 2 * tl;
    ps = (s < 0) ? -s : s;
    if (pl <= pt && pl <= ps) return l;
    if (pt <= ps) return t;
    return tl;
  endfunction

  function automatic pix_t ref_pix(pix_t l, pix_t t, pix_t tl);
    pix_t r;
    r = '0;
    for (int k = 0; k < 3; k++)
      r[k*10 +: 10] = 10'(ref_lane(int'(l[k*10 +: 10]), int'(t[k*10 +: 10]), int'(tl[k*10 +: 10])));
    return r;
  endfunction

  function automatic pix_t put(pix_t bg, int sh, int v);
    pix_t r;
    r = bg;
    r[sh*10 +: 10] = 10'(v);
    return r;
  endfunction

  function automatic pix_t rep(int v);
    return {10'(v), 10'(v), 10'(v)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    ref_px = pix_t'($urandom());
    for (int n = 0; n < 8; n++) begin
      above[n] = pix_t'($urandom());
      left_c[n] = pix_t'($urandom());
    end
  endtask

  task automatic test_reset();
    randomize_inputs();
    #3;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        total++;
        if (pred[i][j] !== '0) begin
          bad++;
          $display("FAIL reset_hold pred[%0d][%0d] got %h want 0", i, j, pred[i][j]);
        end
      end
    step();
    total++;
    if (pred[2][1] !== '0) begin
      bad++;
      $display("FAIL reset_edge pred[2][1] got %h want 0", pred[2][1]);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_mixed(input int sh, input pix_t bg);
    pix_t exp;
    ref_px = put(bg, sh, 150);
    for (int n = 0; n < 8; n++) begin
      above[n] = (n < 4) ? put(bg, sh, a2[n]) : pix_t'($urandom());
      left_c[n] = (n < 4) ? put(bg, sh, l2[n]) : pix_t'($urandom());
    end
    step();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        exp = put(bg, sh, e2[i][j]);
        total++;
        if (pred[i][j] !== exp) begin
          bad++;
          $display("FAIL mixed_lane%0d pred[%0d][%0d] got %h want %h", sh, i, j, pred[i][j], exp);
        end
      end
  endtask

  task automatic test_uniform(input string name, input pix_t tl, input pix_t l, input pix_t t, input pix_t exp);
    ref_px = tl;
    for (int n = 0; n < 8; n++) begin
      above[n] = t;
      left_c[n] = l;
    end
    step();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        total++;
        if (pred[i][j] !== exp) begin
          bad++;
          $display("FAIL %s pred[%0d][%0d] got %h want %h", name, i, j, pred[i][j], exp);
        end
      end
  endtask

  task automatic test_ties();
    test_uniform("tie_equal", rep(77), rep(77), rep(77), rep(77));
    test_uniform("tie_tl", rep(100), rep(110), rep(90), rep(100));
  endtask

  task automatic test_lanes();
    test_mixed(1, {30{1'b1}});
    test_mixed(2, {30{1'b1}});
  endtask

  task automatic test_extremes();
    test_uniform("ext_hi", rep(0), rep(1023), rep(1023), rep(1023));
    test_uniform("ext_lo", rep(1023), rep(0), rep(0), rep(0));
    test_uniform("ext_mix", {10'd0, 10'd1023, 10'd0}, {10'd1023, 10'd0, 10'd1023},
                 {10'd1023, 10'd0, 10'd1023}, {10'd1023, 10'd0, 10'd1023});
  endtask

  task automatic test_back_to_back();
    pix_t exp [0:3][0:3];
    for (int c = 0; c < 8; c++) begin
      randomize_inputs();
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          exp[i][j] = ref_pix(left_c[i], above[j], ref_px);
      step();
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          total++;
          if (pred[i][j] !== exp[i][j]) begin
            bad++;
            $display("FAIL b2b c%0d pred[%0d][%0d] got %h want %h", c, i, j, pred[i][j], exp[i][j]);
          end
        end
    end
  endtask

  task automatic test_unused();
    pix_t exp [0:3][0:3];
    randomize_inputs();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        exp[i][j] = ref_pix(left_c[i], above[j], ref_px);
    step();
    for (int r = 0; r < 3; r++) begin
      for (int n = 4; n < 8; n++) begin
        above[n] = ~above[n];
        left_c[n] = pix_t'($urandom());
      end
      step();
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          total++;
          if (pred[i][j] !== exp[i][j]) begin
            bad++;
            $display("FAIL unused r%0d pred[%0d][%0d] got %h want %h", r, i, j, pred[i][j], exp[i][j]);
          end
        end
    end
  endtask

  task automatic test_async_reset();
    test_uniform("pre_async", rep(0), rep(1023), rep(1023), rep(1023));
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        total++;
        if (pred[i][j] !== '0) begin
          bad++;
          $display("FAIL async_reset pred[%0d][%0d] got %h want 0", i, j, pred[i][j]);
        end
      end
    #2;
    rst_n = 1'b1;
    step();
    total++;
    if (pred[3][3] !== rep(1023)) begin
      bad++;
      $display("FAIL post_reset_load pred[3][3] got %h want %h", pred[3][3], rep(1023));
    end
  endtask

  initial begin
    test_reset();
    test_mixed(0, '0);
    test_ties();
    test_lanes();
    test_extremes();
    test_back_to_back();
    test_unused();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/paeth_mode.md
Name: paeth_mode

Overview:
- AV1 Paeth intra predictor for one fixed 4x4 block.
- Takes the top-left reference pixel, the above-row neighbours and the left-column neighbours, and produces all 16 predicted pixels.
- Outputs are registered: one result per clock, fully pipelined.
- Sits in the intra-prediction stage beside the other directional/smooth mode blocks.

Parameters:
- LANE_W, 10: bits per sample lane.
- LANES, 3: sample lanes packed per pixel word; word width = LANE_W*LANES = 30.
- BLK, 4: block width and height (fixed 4x4).
- NBR, 8: neighbour array depth; only entries 0..BLK-1 are used.

Ports:
- clk  in  1: rising-edge clock.
- rst_n  in  1: asynchronous reset, active-low.
- referencePixel  in  30: top-left neighbour.
- aboveRow  in  30 x [0:7]: above neighbours; index = column.
- leftCol  in  30 x [0:7]: left neighbours; index = row.
- pred  out  30 x [0:3][0:3]: prediction; first index = row i, second index = column j.

Behaviour:
- Each 30-bit word is three independent unsigned 10-bit lanes: [9:0], [19:10], [29:20]. Paeth is computed per lane; no carry or borrow crosses lanes.
- For pred[i][j], per lane:
  - L = leftCol[i], T = aboveRow[j], TL = referencePixel.
  - pLeft = |T - TL|
  - pTop = |L - TL|
  - pTL = |T + L - 2*TL|
  - Result:
    - L if pLeft <= pTop and pLeft <= pTL;
    - else T if pTop <= pTL;
    - else TL.
- Tie rule: ties resolve in the order left, then top, then top-left.
- Arithmetic width: at least 12-bit signed intermediates (range -2046..+2046); no overflow or saturation. The output is always one of the three inputs, so it needs no clipping.
- aboveRow[4..7] and leftCol[4..7] are ignored.
- Latency: pred reflects the inputs sampled at a rising edge of clk, valid immediately after that edge (1-cycle latency). New inputs are accepted every cycle.
- No handshake and no enable; the block is continuously pipelined.
- Reset: while rst_n = 0, all 16 pred words = 0, asynchronously. The first edge after deassertion loads the computed value.
- Reset asserted mid-operation clears pred immediately.
- Path structure: the combinational path is input -> compare -> mux -> register. There is no state machine.

Decomposition:
- Shared package (paeth_pkg):
  - LANE_W, LANES, BLK constants;
  - typedef pix_t (logic [29:0]);
  - typedef sample_t (logic [9:0]).
- Sub-module paeth_lane: purely combinational, single 10-bit lane. Inputs L, T, TL; output the selected sample.
- paeth_mode instantiates 4x4x3 paeth_lane instances in a generate loop and registers their outputs.

Test Plan:
1. Reset: hold rst_n = 0 with arbitrary inputs -> all pred = 0. Assert rst_n low mid-run -> pred drops to 0 without waiting for a clock edge.
2. Mixed vector, lane 0 only:
   - Inputs: referencePixel = 150; aboveRow = {140,235,101,56,...}; leftCol = {5,170,12,230,...}.
   - Required pred rows after 1 edge:
     - row0 = {5,150,5,5}
     - row1 = {170,235,101,56}
     - row2 = {12,150,12,12}
     - row3 = {230,235,150,150}
3. Ties: all inputs equal to 77 -> every pred = 77 (left wins). Separately, TL = 100, L = 110, T = 90 gives pLeft = pTop = 10 and pTL = 0 -> select TL.
4. Lane independence: repeat the case-2 vector with values shifted into bits [19:10] and, separately, into bits [29:20], with other lanes at 1023 -> each lane matches the case-2 result independently, with no cross-lane corruption.
5. Extremes: TL = 0, T = 1023, L = 1023 -> pLeft = 1023, pTop = 1023, pTL = 2046 -> select L = 1023. TL = 1023, T = L = 0 -> select L = 0. No wraparound in either case.
6. Throughput and unused entries:
   - Change inputs every cycle over 8 random cycles -> each pred matches the reference model of the previous cycle's inputs.
   - Toggling aboveRow[4..7] and leftCol[4..7] has no effect on pred.
